// File: rtl/mips32_mem_responder_if.sv
// Request/response bundle between the MIPS32 core (master) and the memory responder (slave).
// Carries the fetch port, the data port and the responder's busy flag.
interface mips32_mem_responder_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              busy;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy
   );
endinterface

// File: rtl/mips32_mem_responder.sv
// Single-ported word memory shared by the fetch and data ports of the MIPS32 core,
// with data-port priority and a fixed number of wait states per access.
module mips32_mem_responder #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int WAIT   = 1
) (
   input  logic clk1,
   input  logic rst,
   mips32_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam int         CNT_INIT = (WAIT > 0) ? WAIT - 1 : 0;
   localparam logic [3:0] CNT_LOAD = CNT_INIT[3:0];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              own_d_q, own_d_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   logic              idle, i_gnt, d_gnt, accept, access;
   logic              acc_own_d, acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   // With zero wait states the access happens on the accept edge itself, so the
   // access operands come straight from the granted port instead of the capture regs.
   always_comb begin
      idle   = (state_q == ST_IDLE);
      d_gnt  = idle & ~rst & bus.d_req;
      i_gnt  = idle & ~rst & bus.i_req & ~bus.d_req;
      accept = d_gnt | i_gnt;
      if (accept) begin
         acc_own_d = d_gnt;
         acc_we    = d_gnt & bus.d_we;
         acc_addr  = d_gnt ? bus.d_addr : bus.i_addr;
         acc_wdata = bus.d_wdata;
         access    = ~rst & (WAIT == 0);
      end else begin
         acc_own_d = own_d_q;
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         access    = ~rst & (state_q == ST_WAIT) & (cnt_q == 4'd0);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      own_d_d    = own_d_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      i_rvalid_d = access & ~acc_own_d;
      d_rvalid_d = access & acc_own_d;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               own_d_d = acc_own_d;
               we_d    = acc_we;
               addr_d  = acc_addr;
               wdata_d = acc_wdata;
               if (WAIT == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read data lands in the owning port's register only; the other port keeps its last word.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         own_d_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         own_d_q    <= own_d_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         if (access && !acc_own_d) i_rdata_q <= mem_q[acc_addr];
         if (access && acc_own_d)  d_rdata_q <= acc_we ? '0 : mem_q[acc_addr];
      end
   end

   always_ff @(posedge clk1) begin
      if (access && acc_own_d && acc_we) mem_q[acc_addr] <= acc_wdata;
   end

   assign bus.i_gnt    = i_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.busy     = (state_q != ST_IDLE);
endmodule
